// File: rtl/cla16_share_arbiter.sv
// Shared 16-bit carry look-ahead adder with a round-robin front end.
// One result register with a valid/ready handshake holds the latest sum,
// tagged with the index of the requester that produced it.

// Two-level 16-bit carry look-ahead adder: four 4-bit groups whose group
// generate/propagate feed a second look-ahead stage for the group carries.
module cla16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout
);

    // Returns carries c1..c4 of a 4-bit look-ahead block from g, p and c0.
    function automatic logic [3:0] lookahead4(input logic [3:0] g,
                                              input logic [3:0] p,
                                              input logic       c0);
        logic [3:0] c;
        c[0] = g[0] | (p[0] & c0);
        c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    logic [15:0] gen;
    logic [15:0] prop;
    logic [3:0]  grp_gen;
    logic [3:0]  grp_prop;
    logic [3:0]  grp_carry;
    logic [16:0] carry;
    logic [3:0]  tmp;

    // Bit and group generate/propagate, group carries, then in-group carries.
    always_comb begin
        gen      = a & b;
        prop     = a ^ b;
        grp_gen  = '0;
        grp_prop = '0;
        carry    = '0;
        tmp      = '0;
        for (int j = 0; j < 4; j++) begin
            tmp         = lookahead4(gen[4*j +: 4], prop[4*j +: 4], 1'b0);
            grp_gen[j]  = tmp[3];
            grp_prop[j] = &prop[4*j +: 4];
        end
        grp_carry = lookahead4(grp_gen, grp_prop, cin);
        carry[0]  = cin;
        for (int j = 0; j < 4; j++) begin
            tmp = lookahead4(gen[4*j +: 4], prop[4*j +: 4], carry[4*j]);
            carry[4*j+1 +: 3] = tmp[2:0];
            carry[4*j+4]      = grp_carry[j];
        end
        s    = prop ^ carry[15:0];
        cout = carry[16];
    end

endmodule

module cla16_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]    req_cin,
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [15:0]        rsp_sum,
    output logic               rsp_cout
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t         state;
    state_t         next_state;
    logic [IDW-1:0] rr_ptr;
    logic [NREQ-1:0] grant;
    logic [IDW-1:0] grant_idx;
    logic           found;
    logic           can_accept;
    logic           accept;
    int             idx;
    logic [15:0]    add_a;
    logic [15:0]    add_b;
    logic           add_cin;
    logic [15:0]    add_s;
    logic           add_cout;

    // Round-robin search starting just after the last winner; nothing is
    // granted in reset or while the held result is blocked.
    always_comb begin
        can_accept = (state == EMPTY) | ((state == FULL) & rsp_ready);
        grant      = '0;
        grant_idx  = '0;
        found      = 1'b0;
        idx        = 0;
        if (rst_n && can_accept) begin
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(rr_ptr) + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    grant_idx   = IDW'(idx);
                end
            end
        end
    end

    assign req_ready = grant;
    assign accept    = found;

    // Steer the granted operands into the shared adder; zeros when idle.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                add_a   = req_a[16*i +: 16];
                add_b   = req_b[16*i +: 16];
                add_cin = req_cin[i];
            end
        end
    end

    cla16 u_cla16 (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .s    (add_s),
        .cout (add_cout)
    );

    // Next state: a grant always fills the register, a drain with no grant empties it.
    always_comb begin
        next_state = state;
        if (accept) begin
            next_state = FULL;
        end else if ((state == FULL) && rsp_ready) begin
            next_state = EMPTY;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Result register and round-robin pointer update on each accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
            rr_ptr   <= IDW'(NREQ - 1);
        end else if (accept) begin
            rsp_id   <= grant_idx;
            rsp_sum  <= add_s;
            rsp_cout <= add_cout;
            rr_ptr   <= grant_idx;
        end
    end

    assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_cla16_share_arbiter.sv
// Directed bench for cla16_share_arbiter: stimulus pushes hand-computed
// results into a scoreboard queue, a monitor pops them on each handshake.
module tb_cla16_share_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] sum;
        logic        cout;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req_valid;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_cin;
    logic [NREQ-1:0]    req_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [15:0]        rsp_sum;
    logic               rsp_cout;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   id_count[NREQ];

    cla16_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic setReq(input int idx, input logic [15:0] a, input logic [15:0] b, input logic cin);
        req_a[16*idx +: 16] = a;
        req_b[16*idx +: 16] = b;
        req_cin[idx]        = cin;
        req_valid[idx]      = 1'b1;
    endtask

    task automatic pushExp(input int idx, input logic [15:0] sum, input logic cout);
        exp_t e;
        e.id   = 2'(idx);
        e.sum  = sum;
        e.cout = cout;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, input logic [15:0] sum, input logic cout);
        setReq(idx, a, b, cin);
        pushExp(idx, sum, cout);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each result consumed by the handshake is checked against the
    // next scoreboard entry; reset discards whatever is still expected.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected", 32'(rsp_sum), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("sb_id", 32'(rsp_id), 32'(e.id));
                checkOutput("sb_sum", 32'(rsp_sum), 32'(e.sum));
                checkOutput("sb_cout", 32'(rsp_cout), 32'(e.cout));
                id_count[rsp_id]++;
            end
        end
    end

    // Directed stimulus sequence.
    initial begin
        logic [3:0]  grant_seq [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        int          id_seq    [6] = '{0, 1, 2, 3, 0, 1};
        logic [15:0] sum_seq   [4] = '{16'h0003, 16'h0001, 16'h5555, 16'h0000};
        logic        cout_seq  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < NREQ; i++) id_count[i] = 0;
        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        // Reset with every requester asserting valid.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
        checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'd0);
        checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
        tick();
        rst_n     = 1'b1;
        req_valid = '0;

        // Single request from requester 0, one-cycle latency.
        applyStimulus(0, 16'h1234, 16'h1001, 1'b0, 16'h2235, 1'b0);
        @(negedge clk);
        checkOutput("t2_grant", 32'(req_ready), 32'b0001);
        checkOutput("t2_not_yet_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = '0;
        @(negedge clk);
        checkOutput("t2_rsp_valid", 32'(rsp_valid), 32'd1);
        checkOutput("t2_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("t2_rsp_sum", 32'(rsp_sum), 32'h2235);
        checkOutput("t2_rsp_cout", 32'(rsp_cout), 32'd0);
        tick();

        // Carry/overflow cases on requester 2, back to back.
        applyStimulus(2, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("t3_grant_a", 32'(req_ready), 32'b0100);
        tick();
        applyStimulus(2, 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        checkOutput("t3_grant_b", 32'(req_ready), 32'b0100);
        tick();
        applyStimulus(2, 16'h0F0F, 16'h00FF, 1'b0, 16'h100E, 1'b0);
        @(negedge clk);
        checkOutput("t3_grant_c", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        checkOutput("t3_last_sum", 32'(rsp_sum), 32'h100E);
        tick();

        // Backpressure: result held while requester 1 waits.
        rsp_ready = 1'b0;
        applyStimulus(1, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        @(negedge clk);
        checkOutput("t5_first_grant", 32'(req_ready), 32'b0010);
        tick();
        applyStimulus(1, 16'hC000, 16'h4000, 1'b1, 16'h0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t5_hold_ready", 32'(req_ready), 32'd0);
            checkOutput("t5_hold_valid", 32'(rsp_valid), 32'd1);
            checkOutput("t5_hold_sum", 32'(rsp_sum), 32'h8000);
            checkOutput("t5_hold_id", 32'(rsp_id), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("t5_release_grant", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        @(negedge clk);
        checkOutput("t5_new_sum", 32'(rsp_sum), 32'h0001);
        checkOutput("t5_new_cout", 32'(rsp_cout), 32'd1);
        tick();

        // Fresh reset so arbitration restarts at requester 0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;

        // Fairness: all four requesters continuously valid.
        setReq(0, 16'h0001, 16'h0002, 1'b0);
        setReq(1, 16'h8000, 16'h8000, 1'b1);
        setReq(2, 16'h1234, 16'h4321, 1'b0);
        setReq(3, 16'hFFFE, 16'h0001, 1'b1);
        for (int k = 0; k < 6; k++) pushExp(id_seq[k], sum_seq[id_seq[k]], cout_seq[id_seq[k]]);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("t4_grant", 32'(req_ready), 32'(grant_seq[k]));
            if (k > 0) checkOutput("t4_rsp_id", 32'(rsp_id), 32'(id_seq[k-1]));
            tick();
        end

        // Reset in the middle of the stream.
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("t6_rst_ready", 32'(req_ready), 32'd0);
        checkOutput("t6_held_id", 32'(rsp_id), 32'd1);
        checkOutput("t6_held_sum", 32'(rsp_sum), 32'h0001);
        tick();
        rst_n = 1'b1;
        pushExp(0, sum_seq[0], cout_seq[0]);
        pushExp(1, sum_seq[1], cout_seq[1]);
        @(negedge clk);
        checkOutput("t6_valid_dropped", 32'(rsp_valid), 32'd0);
        checkOutput("t6_restart_grant", 32'(req_ready), 32'b0001);
        tick();
        @(negedge clk);
        checkOutput("t6_second_grant", 32'(req_ready), 32'b0010);
        checkOutput("t6_first_id", 32'(rsp_id), 32'd0);
        tick();
        req_valid = '0;
        repeat (3) tick();

        checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
        checkOutput("count_id0", 32'(id_count[0]), 32'd4);
        checkOutput("count_id1", 32'(id_count[1]), 32'd4);
        checkOutput("count_id2", 32'(id_count[2]), 32'd4);
        checkOutput("count_id3", 32'(id_count[3]), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
